// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the datapath-to-memory bridge.
package mem_bus_bridge_pkg;

    // Bridge FSM states; encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    // A byte address is usable only when it points at the start of a word.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_bridge.sv
// Bridge between the multi-cycle datapath memory port and a variable-latency
// word-addressed memory with a req/ack handshake.
//
// Handshake: mem_req is held high (with mem_addr/mem_we/mem_wdata stable)
// until the memory returns a one-cycle mem_ack; mem_rdata is only looked at
// in that ack cycle. mem_ack seen outside a request is ignored. cpu_stall
// tells the control FSM to hold its state; the cycle in which cpu_stall is
// low after an access (RESP or ERR) is the completion cycle.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              in_reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_e            dbg_state
);

    // Counter limit as an 8-bit constant; TIMEOUT never exceeds 255.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cnt_inc;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stall;
    logic              any_req;
    logic              legal_req;

    assign cnt_inc   = cnt_q + 8'd1;
    assign any_req   = cpu_read | cpu_write;
    // Exactly one of read/write, on a word boundary.
    assign legal_req = (cpu_read ^ cpu_write) && is_word_aligned(cpu_addr[1:0]);

    // Next-state, capture and stall decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // While reset is held nothing is accepted, so stall stays low.
                if (in_reset && any_req) begin
                    stall = 1'b1;
                    if (legal_req) begin
                        state_d = ST_REQ;
                        addr_d  = cpu_addr[ADDR_W-1:2];
                        wdata_d = cpu_wdata;
                        we_d    = cpu_write;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-side and CPU-side outputs decoded from the registered state so
    // they fall as soon as reset asserts.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_err   = (state_q == ST_ERR);
    assign cpu_stall = stall;
    assign cpu_rdata = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed cases followed by random
// accesses, a memory responder with programmable ack delay and stray acks,
// and a monitor that checks each completed access against a queue of
// expected outcomes.
module tb_mem_bus_bridge;

    localparam int TO = 4;

    typedef struct packed {
        bit          is_err;
        logic [7:0]  req_cycles;
        logic [7:0]  stall_cycles;
        logic [29:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        in_reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    mem_bus_bridge_pkg::state_e dbg_state;

    exp_t        exp_q[$];
    int          n_vec;
    int          n_miss;
    int          cur_delay;
    logic [31:0] cur_rdata;
    bit          stray_en;
    logic [31:0] last_rd;

    mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .in_reset  (in_reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
        chk({tag, "_cpu_err"},   {31'd0, cpu_err},   32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata,          32'd0);
        chk({tag, "_mem_addr"},  {2'd0, mem_addr},   32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
    endtask

    // Memory responder: acks on the cur_delay-th request cycle (0 = never),
    // and may throw stray acks while no request is outstanding.
    initial begin
        int rcnt;
        rcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!in_reset) begin
                rcnt    = 0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                rcnt++;
                if (rcnt == cur_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur_rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                rcnt = 0;
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard: tracks the current access and compares at its
    // completion cycle (error pulse, or the first cycle after mem_req drops).
    int          req_cnt;
    int          stall_cnt;
    bit          prev_req;
    logic [29:0] cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    exp_t        e;

    always @(negedge clk) begin
        if (!in_reset) begin
            req_cnt   = 0;
            stall_cnt = 0;
            prev_req  = 1'b0;
        end else begin
            if (cpu_stall === 1'b1) stall_cnt++;
            if (mem_req === 1'b1) begin
                req_cnt++;
                chk("stall_during_req", {31'd0, cpu_stall}, 32'd1);
                if (req_cnt == 1) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else begin
                    chk("mem_addr_stable",  {2'd0, mem_addr}, {2'd0, cap_addr});
                    chk("mem_wdata_stable", mem_wdata,        cap_wdata);
                    chk("mem_we_stable",    {31'd0, mem_we},  {31'd0, cap_we});
                end
            end
            if (cpu_err === 1'b1 || (prev_req && mem_req === 1'b0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", {31'd0, cpu_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cpu_err",      {31'd0, cpu_err},   {31'd0, e.is_err});
                    chk("stall_at_end", {31'd0, cpu_stall}, 32'd0);
                    chk("req_cycles",   req_cnt,            {24'd0, e.req_cycles});
                    chk("stall_cycles", stall_cnt,          {24'd0, e.stall_cycles});
                    chk("cpu_rdata",    cpu_rdata,          e.rdata);
                    if (e.req_cycles != 0) begin
                        chk("mem_addr",  {2'd0, cap_addr}, {2'd0, e.addr});
                        chk("mem_we",    {31'd0, cap_we},  {31'd0, e.we});
                        if (e.we) chk("mem_wdata", cap_wdata, e.wdata);
                    end
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
            prev_req = (mem_req === 1'b1);
        end
    end

    // Reference outcome of one access from the bridge's rules, then drive it
    // the way the control FSM would: hold the request until stall drops.
    // Called and returns at 1 time unit after a rising edge, in IDLE.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int delay,
                             input logic [31:0] rdata);
        exp_t x;
        int   n;
        x = '0;
        if (!(rd ^ wr) || addr[1:0] != 2'b00) begin
            x.is_err       = 1'b1;
            x.req_cycles   = 8'd0;
            x.stall_cycles = 8'd1;
        end else begin
            x.addr  = addr[31:2];
            x.we    = wr;
            x.wdata = wdata;
            if (delay >= 1 && delay <= TO) begin
                x.is_err       = 1'b0;
                x.req_cycles   = 8'(delay);
                if (rd) last_rd = rdata;
            end else begin
                x.is_err       = 1'b1;
                x.req_cycles   = 8'(TO);
            end
            x.stall_cycles = x.req_cycles + 8'd1;
        end
        x.rdata = last_rd;
        exp_q.push_back(x);

        cur_delay = delay;
        cur_rdata = rdata;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall === 1'b1 && n < 40);
        if (cpu_stall === 1'b1) chk("stall_bound", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Main stimulus
    initial begin
        int          kind;
        int          dly;
        logic [31:0] a;
        bit          rd;
        bit          wr;

        n_vec     = 0;
        n_miss    = 0;
        last_rd   = 32'd0;
        stray_en  = 1'b0;
        cur_delay = 0;
        cur_rdata = 32'd0;
        in_reset  = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        in_reset = 1'b1;
        idle(1);

        // Read acked on the 3rd request cycle, then write acked on the 1st.
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678);
        idle(1);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'hDEAD_BEEF);
        idle(1);

        // Timeout with no ack, then ack on the last allowed cycle.
        do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0BAD_0BAD);
        idle(1);
        do_access(1'b0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, TO, 32'h0);
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, TO, 32'hA5A5_0F0F);
        idle(1);

        // Illegal requests.
        do_access(1'b1, 1'b1, 32'h0000_0050, 32'h1111_1111, 1, 32'h2222_2222);
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1, 32'h3333_3333);
        idle(1);

        // Asynchronous reset between clock edges during a request.
        cur_delay = 0;
        cur_rdata = 32'h7777_7777;
        cpu_read  = 1'b1;
        cpu_addr  = 32'h0000_0080;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
        in_reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        cpu_read = 1'b0;
        last_rd  = 32'd0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 2, 32'h8888_9999);

        // Back-to-back reads with stray acks while idle.
        stray_en = 1'b1;
        idle(2);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h0101_0101);
        do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, 32'h0202_0202);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            a[1:0] = 2'b00;
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind <= 4) rd = 1'b1;
            else if (kind <= 7) wr = 1'b1;
            else if (kind == 8) begin
                rd = 1'b1;
                wr = 1'b1;
            end else begin
                rd = 1'b1;
                a[1:0] = 2'($urandom_range(1, 3));
            end
            dly = $urandom_range(0, TO + 2);
            do_access(rd, wr, a, $urandom, dly, $urandom);
            idle($urandom_range(0, 2));
        end

        stray_en = 1'b0;
        idle(4);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the multi-cycle datapath's memory port and an external word-addressed memory with variable latency and a req/ack handshake.
- Latches each datapath read or write and drives it to memory.
- Asserts cpu_stall so the control FSM holds its state until the access completes, or until a timeout or a protocol error ends it.
- Read data is registered so the datapath's IR/MDR can sample it in the completion cycle.

Parameters:
- ADDR_W, 32, datapath byte-address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum REQ cycles without mem_ack before abort; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- in_reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  byte address (PC or ALU_out_hold, muxed upstream).
- cpu_wdata  in  DATA_W  store data (B register).
- cpu_read  in  1  MemRead from control.
- cpu_write  in  1  MemWrite from control.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_stall  out  1  control must hold its current state while high.
- cpu_err  out  1  one-cycle error pulse.
- mem_req  out  1  request to memory, held until ack.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W-2  word address = cpu_addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  DATA_W  valid only while mem_ack is high.

Behaviour:
- Reset (async, in_reset=0):
  - state=IDLE.
  - mem_req, mem_we, cpu_err, cpu_stall = 0.
  - cpu_rdata, mem_addr, mem_wdata = 0.
  - timeout counter = 0.
  - An in-flight access is abandoned; mem_req falls immediately, without waiting for the clock.
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - Exactly one of cpu_read/cpu_write high and cpu_addr[1:0]==0: capture addr/wdata/we into registers, go to REQ. cpu_stall=1 combinationally in this cycle.
  - cpu_read and cpu_write both high, or misaligned address: go to ERR, no memory request. cpu_stall=1 in this cycle.
  - Neither high: stay in IDLE, cpu_stall=0.
- REQ:
  - mem_req=1, mem_we=captured we; address and data held stable; cpu_stall=1.
  - Counter increments each cycle.
  - mem_ack=1: go to RESP. On a read, cpu_rdata<=mem_rdata.
  - Counter reaches TIMEOUT with mem_ack=0: go to ERR, mem_req drops next cycle.
  - mem_ack in the same cycle the counter hits TIMEOUT: ack wins, go to RESP.
  - Changes on cpu_read/cpu_write/cpu_addr during REQ are ignored.
- RESP:
  - mem_req=0, cpu_stall=0; cpu_rdata is valid; control advances on this edge.
  - Request inputs in this cycle belong to the completing access and are ignored.
  - Always go to IDLE.
- ERR:
  - cpu_err=1 for exactly this cycle, cpu_stall=0, mem_req=0, cpu_rdata unchanged.
  - Always go to IDLE.
- Minimum latency: a request in IDLE with ack on the first REQ cycle means 2 stall cycles, then RESP.
- Back-to-back: a new request can be accepted in the IDLE cycle after RESP, giving one dead cycle between accesses.
- cpu_rdata holds its value until the next successful read; writes do not alter it.
- mem_ack outside REQ is ignored, with no state change.
- Counter is 8 bits and is cleared on entry to REQ; no wrap is possible because TIMEOUT ≤ 255.

Decomposition:
- Shared package contents:
  - state enum (IDLE/REQ/RESP/ERR, 2-bit encoding 0..3);
  - DEFAULT_TIMEOUT = 255;
  - WORD_ALIGN_MASK = 2'b11.
- No sub-module needed. The timeout counter is inline.
- The block instantiates in the datapath in place of the direct Data_Memory connection. cpu_stall gates the control FSM's next-state update.

Test Plan:
- Read, ack on 3rd REQ cycle: cpu_read=1, cpu_addr=32'h0000_0010, mem_rdata=32'h1234_5678 → mem_addr=30'h4; mem_req high 3 cycles; cpu_stall high 4 cycles; RESP cycle cpu_rdata=32'h1234_5678, cpu_stall=0.
- Write, ack on 1st REQ cycle: cpu_write=1, cpu_addr=32'h0000_0020, cpu_wdata=32'hCAFE_F00D → mem_we=1, mem_wdata=32'hCAFE_F00D, mem_addr=30'h8; cpu_rdata unchanged; cpu_err=0.
- Timeout with TIMEOUT=4, mem_ack held 0 → mem_req high exactly 4 cycles; then one cycle of cpu_err=1, cpu_stall=0; back to IDLE. Repeat with ack on the 4th REQ cycle → RESP, no error.
- Illegal requests:
  - cpu_read=cpu_write=1 → no mem_req, cpu_err pulse on the next cycle.
  - cpu_addr=32'h0000_0002 read → same response.
- Async reset mid-REQ: in_reset low between clock edges during REQ → mem_req=0 and cpu_stall=0 immediately; all outputs at reset values; after release, a new read completes normally.
- Back-to-back reads (fetch then load): addresses 0x0 then 0x4, each acked on 1st REQ cycle → two transactions with one IDLE cycle between; cpu_rdata updates in each RESP cycle; a stray mem_ack in IDLE is ignored.
